// File: rtl/add_8bit.sv
// Registered unsigned adder/subtractor with carry/borrow, signed-overflow and zero flags; ADD8_SATURATE_EN selects unsigned saturation.
// Latency: 1 cycle from an in_valid capture edge to result/flags with out_valid.
// Backpressure: none; accepts one op every cycle, and outputs hold while in_valid is low.
module add_8bit #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             out_valid
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] b_op;
    logic [WIDTH:0]   sum_full;
    logic [WIDTH-1:0] raw_res;
    logic             raw_carry;
    logic             raw_ovf;
    logic [WIDTH-1:0] final_res;

    logic [WIDTH-1:0] result_d, result_q;
    logic             carry_d, carry_q;
    logic             overflow_d, overflow_q;
    logic             zero_d, zero_q;
    logic             out_valid_d, out_valid_q;

    // Subtraction is a + ~b + 1; the top bit is then "no borrow", so it is inverted for carry.
    always_comb begin
        b_op      = sub ? ~b : b;
        sum_full  = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, sub};
        raw_res   = sum_full[WIDTH-1:0];
        raw_carry = sub ? ~sum_full[WIDTH] : sum_full[WIDTH];
        if (sub) begin
            raw_ovf = (a[MSB] != b[MSB]) && (raw_res[MSB] != a[MSB]);
        end else begin
            raw_ovf = (a[MSB] == b[MSB]) && (raw_res[MSB] != a[MSB]);
        end
    end

`ifdef ADD8_SATURATE_EN
    always_comb begin
        final_res = raw_res;
        if (raw_carry) begin
            final_res = sub ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
        end
    end
`else
    always_comb begin
        final_res = raw_res;
    end
`endif

    always_comb begin
        result_d    = result_q;
        carry_d     = carry_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            result_d   = final_res;
            carry_d    = raw_carry;
            overflow_d = raw_ovf;
            zero_d     = (final_res == '0);
        end
    end

    // zero resets to 1 regardless of RESET_VAL, so it reads as idle after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q    <= RESET_VAL;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            carry_q     <= carry_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign result    = result_q;
    assign carry     = carry_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_add_8bit.sv
// Randomized and directed bench for add_8bit against an integer-arithmetic reference model.
module tb_add_8bit;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] result;
    logic       carry;
    logic       overflow;
    logic       zero;
    logic       out_valid;

    int n_tests;
    int n_fail;

    logic [7:0] m_res;
    logic       m_c;
    logic       m_o;
    logic       m_z;

    add_8bit #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .result    (result),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    task automatic model(input logic s, input logic [7:0] x, input logic [7:0] y);
        int ux, uy, sx, sy, r, sr;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (!s) begin
            r   = ux + uy;
            m_c = (r > 255);
            sr  = sx + sy;
        end else begin
            r   = ux - uy;
            m_c = (ux < uy);
            sr  = sx - sy;
        end
        m_o   = (sr > 127) || (sr < -128);
        m_res = r[7:0];
`ifdef ADD8_SATURATE_EN
        if (m_c) m_res = s ? 8'h00 : 8'hFF;
`endif
        m_z = (m_res == 8'h00);
    endtask

    task automatic model_reset();
        m_res = 8'h00;
        m_c   = 1'b0;
        m_o   = 1'b0;
        m_z   = 1'b1;
    endtask

    task automatic check_all(input string tag, input logic exp_vld);
        chk({tag, ".result"}, 32'(result), 32'(m_res));
        chk({tag, ".carry"}, 32'(carry), 32'(m_c));
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_o));
        chk({tag, ".zero"}, 32'(zero), 32'(m_z));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(exp_vld));
    endtask

    // One cycle: drive at negedge, check #1 after the following posedge.
    task automatic apply(input string tag, input logic vld, input logic s, input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        in_valid = vld;
        sub      = s;
        a        = x;
        b        = y;
        @(posedge clk);
        #1;
        if (vld) model(s, x, y);
        check_all(tag, vld);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        sub      = 1'b0;
        a        = 8'h00;
        b        = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        apply("add00", 1'b1, 1'b0, 8'h00, 8'h00);
        chk("add00.const", 32'(result), 32'h00);
        apply("add5_6", 1'b1, 1'b0, 8'h05, 8'h06);
        chk("add5_6.const", 32'(result), 32'h0B);
        apply("add7_8", 1'b1, 1'b0, 8'h07, 8'h08);
        chk("add7_8.const", 32'(result), 32'h0F);
        apply("addAA_1", 1'b1, 1'b0, 8'hAA, 8'h01);
        apply("add7F_1", 1'b1, 1'b0, 8'h7F, 8'h01);
        chk("add7F_1.ovf", 32'(overflow), 32'h1);
        apply("addFF_FF", 1'b1, 1'b0, 8'hFF, 8'hFF);
`ifdef ADD8_SATURATE_EN
        chk("addFF_FF.const", 32'(result), 32'hFF);
`else
        chk("addFF_FF.const", 32'(result), 32'hFE);
`endif
        apply("sub5_6", 1'b1, 1'b1, 8'h05, 8'h06);
`ifdef ADD8_SATURATE_EN
        chk("sub5_6.const", 32'(result), 32'h00);
`else
        chk("sub5_6.const", 32'(result), 32'hFF);
`endif
        apply("sub10_10", 1'b1, 1'b1, 8'h10, 8'h10);
        apply("sub80_01", 1'b1, 1'b1, 8'h80, 8'h01);
        apply("sub33_12", 1'b1, 1'b1, 8'h33, 8'h12);
        for (int i = 0; i < 3; i++) begin
            apply("hold", 1'b0, 1'($urandom), 8'($urandom), 8'($urandom));
        end

        // Async reset in the middle of a cycle, with an op pending.
        apply("pre_rst", 1'b1, 1'b0, 8'h41, 8'h22);
        @(negedge clk);
        in_valid = 1'b1;
        a        = 8'h12;
        b        = 8'h34;
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst", 1'b0);
        @(posedge clk);
        #1;
        check_all("rst_held", 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        apply("post_rst", 1'b0, 1'b0, 8'h00, 8'h00);

        for (int i = 0; i < 1000; i++) begin
            apply("rand", ($urandom_range(0, 9) < 8), 1'($urandom), 8'($urandom), 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
